// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and oversampling constants for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = $clog2(OVERSAMPLE);
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line, resets to the idle-high level
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else if (!clr) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 16x oversampled UART receive controller with majority-vote bit sampling
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Bclkx16_,
  input  logic                 reset,
  input  logic                 rst,
  input  logic                 RxD,
  output logic [0:DATA_BITS-1] data,
  output logic                 Rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(SAMPLE_LO);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_LO + 1);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(SAMPLE_HI);
  localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);

  rx_state_t            state, state_d;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [0:DATA_BITS-1] shreg;
  logic                 rxs, s_lo, s_mid, par_bit, armed;
  logic                 vote, at_hi, wrap, par_mismatch;
  logic                 done, shift_en, par_en, idx_clr, idx_inc;

  uart_rx_sync u_sync (
    .clk   (Bclkx16_),
    .reset (reset),
    .clr   (rst),
    .d     (RxD),
    .q     (rxs)
  );

  // Two earlier samples are registered; the third is the live value at the decision count.
  assign vote  = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
  assign at_hi = (cnt == CNT_HI);
  assign wrap  = (cnt == CNT_WRAP);
  assign busy  = (state != IDLE);

  assign par_mismatch = (PARITY_EN != 0) ? ((^shreg) ^ par_bit ^ ODD) : 1'b0;

  always_ff @(posedge Bclkx16_ or negedge reset) begin
    if (!reset)    state <= IDLE;
    else if (!rst) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d  = state;
    done     = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rxs) state_d = START;
      end
      START: begin
        if (at_hi && vote) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_clr = 1'b1;
        end
      end
      DATA: begin
        shift_en = at_hi;
        if (wrap) begin
          if (idx == IDX_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                 idx_inc = 1'b1;
        end
      end
      PARITY: begin
        par_en = at_hi;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Returning half a bit early leaves room to catch a back-to-back start edge.
        if (at_hi) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Bclkx16_ or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      s_lo       <= 1'b1;
      s_mid      <= 1'b1;
      par_bit    <= 1'b0;
      armed      <= 1'b1;
      data       <= '0;
      Rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      s_lo       <= 1'b1;
      s_mid      <= 1'b1;
      par_bit    <= 1'b0;
      armed      <= 1'b1;
      data       <= '0;
      Rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state_d == IDLE) ? '0 : cnt + 1'b1;
      if (cnt == CNT_LO)  s_lo  <= rxs;
      if (cnt == CNT_MID) s_mid <= rxs;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (shift_en) shreg[idx] <= vote;
      if (par_en)   par_bit    <= vote;
      Rx_done <= done;
      if (done) begin
        data       <= shreg;
        frame_err  <= ~vote;
        parity_err <= par_mismatch;
      end
      // A break holds off new starts until the line has been seen idle again.
      if (done && !vote)            armed <= 1'b0;
      else if (state == IDLE && rxs) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - frame-level reference bench for uart_rx_ctrl, plain and even-parity builds
module tb_uart_rx_ctrl;

  localparam int BIT_T = 16;
  // Start edge driven -> 2 sync flops -> IDLE decision, then T154 / T170 from the first START cycle.
  localparam int LAT0  = 3 + 154;
  localparam int LAT1  = 3 + 170;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, rst, rxd0, rxd1;
  logic [0:7] data0, data1;
  logic       done0, done1, fe0, fe1, pe0, pe1, busy0, busy1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  ev_t        q0[$];
  ev_t        q1[$];

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .Bclkx16_(clk), .reset(reset), .rst(rst), .RxD(rxd0), .data(data0),
    .Rx_done(done0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .Bclkx16_(clk), .reset(reset), .rst(rst), .RxD(rxd1), .data(data1),
    .Rx_done(done1), .frame_err(fe1), .parity_err(pe1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] to_byte(input logic [0:7] w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = w[i];
    return b;
  endfunction

  always @(negedge clk) begin
    if (done0) q0.push_back('{cyc, to_byte(data0), fe0, pe0});
    if (done1) q1.push_back('{cyc, to_byte(data1), fe1, pe1});
  end

  function automatic logic even_perr(input logic [7:0] b, input logic p);
    return ($countones({b, p}) % 2) != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd0 = v;
    else          rxd1 = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (BIT_T) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic par,
                            input logic stop, output int t0);
    t0 = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    if (sel == 1) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic check_frame(input int sel, input int t0, input logic [7:0] b,
                             input logic fe, input logic pe);
    ev_t ev;
    int  n;
    n = (sel == 0) ? q0.size() : q1.size();
    chk("rx_done_seen", 32'(n > 0), 32'd1);
    if (n > 0) begin
      ev = (sel == 0) ? q0.pop_front() : q1.pop_front();
      chk("rx_done_cycle", ev.cyc, t0 + ((sel == 0) ? LAT0 : LAT1));
      chk("data", {24'd0, ev.d}, {24'd0, b});
      chk("frame_err", {31'd0, ev.fe}, {31'd0, fe});
      chk("parity_err", {31'd0, ev.pe}, {31'd0, pe});
    end
  endtask

  initial begin
    int         t0, t1;
    logic [7:0] b;
    logic       p;

    reset = 1'b0;
    rst   = 1'b1;
    rxd0  = 1'b1;
    rxd1  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_done", {31'd0, done0}, 32'd0);
    chk("reset_data", {24'd0, data0}, 32'd0);
    chk("reset_frame_err", {31'd0, fe0}, 32'd0);
    chk("reset_busy", {30'd0, busy0, busy1}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(0, 8'hA5, 1'b0, 1'b1, t0);
    check_frame(0, t0, 8'hA5, 1'b0, 1'b0);

    rxd0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("false_start_busy", {31'd0, busy0}, 32'd1);
    rxd0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("false_start_no_done", q0.size(), 32'd0);
    chk("false_start_idle", {31'd0, busy0}, 32'd0);

    send_frame(0, 8'h3C, 1'b0, 1'b0, t0);
    repeat (40) @(negedge clk);
    check_frame(0, t0, 8'h3C, 1'b1, 1'b0);
    chk("break_no_restart", {31'd0, busy0}, 32'd0);
    chk("break_no_extra", q0.size(), 32'd0);
    rxd0 = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(0, 8'h81, 1'b0, 1'b1, t0);
    check_frame(0, t0, 8'h81, 1'b0, 1'b0);

    send_frame(0, 8'h55, 1'b0, 1'b1, t0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, t1);
    check_frame(0, t0, 8'h55, 1'b0, 1'b0);
    check_frame(0, t1, 8'hFF, 1'b0, 1'b0);
    chk("b2b_spacing", t1 - t0, 32'd160);

    b = 8'h6B;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, b[i]);
    rxd0 = b[4];
    repeat (8) @(negedge clk);
    chk("midframe_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b0;
    rxd0  = 1'b1;
    #1;
    chk("async_reset_data", {24'd0, data0}, 32'd0);
    chk("async_reset_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("reset_frame_dropped", q0.size(), 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b1, t0);
    check_frame(0, t0, 8'h12, 1'b0, 1'b0);

    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst = 1'b0;
    rxd0 = 1'b1;
    @(negedge clk);
    chk("clr_busy", {31'd0, busy0}, 32'd0);
    chk("clr_data", {24'd0, data0}, 32'd0);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("clr_frame_dropped", q0.size(), 32'd0);

    send_frame(1, 8'h07, 1'b1, 1'b1, t0);
    check_frame(1, t0, 8'h07, 1'b0, 1'b0);
    send_frame(1, 8'h07, 1'b0, 1'b1, t0);
    check_frame(1, t0, 8'h07, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(0, b, 1'b0, 1'b1, t0);
      check_frame(0, t0, b, 1'b0, 1'b0);
      b = 8'($urandom);
      p = 1'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(1, b, p, 1'b1, t0);
      check_frame(1, t0, b, 1'b0, even_perr(b, p));
    end

    repeat (20) @(negedge clk);
    chk("no_stray_done0", q0.size(), 32'd0);
    chk("no_stray_done1", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
